// File: rtl/afifo_wr_arbiter_pkg.sv
// Shared write-side FIFO definitions: datapath width, word type and the
// arbiter state encoding used by the round-robin push-port arbiter.
package afifo_wr_arbiter_pkg;

  localparam int D_WIDTH           = 8;
  localparam int F_DEPTH           = 16;
  localparam int MAX_BURST_DEFAULT = 4;

  typedef logic [D_WIDTH-1:0] data_ty;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/afifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester with req high, scanning
// upward from rr_ptr with an explicit modulo-N_REQ wrap.
module afifo_wr_arbiter_rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] rr_ptr,
  output logic [N_REQ-1:0]         winner,
  output logic                     valid
);

  localparam int PW = $clog2(N_REQ);

  int            idx;
  logic [PW-1:0] sel;

  always_comb begin
    // NOTE: every variable gets a default before the loop, so no path through
    // this block leaves a value unassigned and no latch is inferred.
    winner = '0;
    valid  = 1'b0;
    idx    = 0;
    sel    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = PW'(idx);
      if (!valid && req[sel]) begin
        winner[sel] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/afifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO push port among N_REQ
// producers; one grant at a time, up to MAX_BURST words per grant.
module afifo_wr_arbiter
  import afifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         last,
  input  logic [N_REQ*D_WIDTH-1:0] data_in,
  output logic [N_REQ-1:0]         ack,
  output logic [N_REQ-1:0]         gnt,
  input  logic                     fifo_full,
  output logic                     fifo_push,
  output data_ty                   fifo_wdata,
  output logic                     busy
);

  localparam int            PW       = $clog2(N_REQ);
  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  arb_state_e       state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    g_idx;
  logic [PW-1:0]    next_ptr;
  logic [CW-1:0]    burst_cnt;
  logic [N_REQ-1:0] pick;
  logic             pick_valid;
  logic             req_g;
  logic             last_g;
  logic             burst_done;

  afifo_wr_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick),
    .valid  (pick_valid)
  );

  // Word and index of the granted requester; both are zero while idle.
  always_comb begin
    g_idx      = '0;
    fifo_wdata = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        g_idx      = PW'(i);
        fifo_wdata = data_in[i*D_WIDTH +: D_WIDTH];
      end
    end
  end

  assign req_g      = |(req & gnt);
  assign last_g     = |(last & gnt);
  assign fifo_push  = (state == BURST) & req_g & ~fifo_full;
  assign ack        = gnt & {N_REQ{fifo_push}};
  assign burst_done = fifo_push & (last_g | (burst_cnt == CNT_LAST));
  assign next_ptr   = (g_idx == PW'(N_REQ - 1)) ? '0 : g_idx + 1'b1;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            gnt       <= pick;
            burst_cnt <= '0;
            busy      <= 1'b1;
            state     <= BURST;
          end
        end
        BURST: begin
          if (fifo_push) burst_cnt <= burst_cnt + 1'b1;
          // A withdrawn request exits even while the FIFO is full.
          if (burst_done || !req_g) begin
            gnt    <= '0;
            busy   <= 1'b0;
            rr_ptr <= next_ptr;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
